pc_gen: RTL

//  Parametrised program-counter generator for the fetch stage. Holds the

---
 rtl/pc_gen.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with stall, exception redirect and a
// circular return-address stack that overwrites its oldest entry when full.
module pc_gen #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = 32'h80000000,
  parameter logic [WIDTH-1:0]  EXC_VEC   = 32'h80000180,
  parameter int unsigned       INC       = 4,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc,
  input  logic             ret,
  input  logic             jump,
  input  logic             link,
  input  logic             branch,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] ia,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             align_err
);

  localparam int unsigned PtrW   = $clog2(RAS_DEPTH);
  localparam int unsigned CntW   = $clog2(RAS_DEPTH + 1);
  localparam int unsigned AlignW = $clog2(INC);
  // Low address bits that must be zero for an INC-aligned fetch address.
  localparam logic [WIDTH-1:0] AlignMask = WIDTH'((64'd1 << AlignW) - 64'd1);
  localparam logic [CntW-1:0]  CntMax    = CntW'(RAS_DEPTH);
  localparam logic [CntW-1:0]  CntOne    = CntW'(1);
  localparam logic [PtrW-1:0]  PtrOne    = PtrW'(1);

  logic [WIDTH-1:0] ia_q, ia_d;
  logic [PtrW-1:0]  top_q, top_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             align_err_q, align_err_d;

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic             ras_we;
  logic [PtrW-1:0]  ras_waddr;
  logic [WIDTH-1:0] ras_wdata;

  logic [WIDTH-1:0] ia_inc;
  logic [WIDTH-1:0] tgt_aligned;
  logic             tgt_misaligned;
  logic             cnt_full;

  assign ia_inc         = ia_q + WIDTH'(INC);
  assign tgt_aligned    = target & ~AlignMask;
  assign tgt_misaligned = |(target & AlignMask);
  assign cnt_full       = (cnt_q == CntMax);

  // Next-state selection; requests are resolved in strict priority order.
  always_comb begin
    ia_d        = ia_q;
    top_d       = top_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    align_err_d = 1'b0;
    ras_we      = 1'b0;
    ras_waddr   = top_q + PtrOne;
    ras_wdata   = ia_inc;

    if (exc) begin
      ia_d  = EXC_VEC;
      cnt_d = '0;
    end else if (stall) begin
      // hold everything; align_err drops via its default
    end else if (ret) begin
      if (cnt_q != '0) begin
        ia_d  = ras_q[top_q];
        top_d = top_q - PtrOne;
        cnt_d = cnt_q - CntOne;
      end else begin
        ia_d        = tgt_aligned;
        align_err_d = tgt_misaligned;
      end
    end else if (jump) begin
      ia_d        = tgt_aligned;
      align_err_d = tgt_misaligned;
      if (link) begin
        // When full the new top lands on the oldest slot, overwriting it.
        ras_we = 1'b1;
        top_d  = top_q + PtrOne;
        if (cnt_full) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
    end else if (branch) begin
      ia_d        = tgt_aligned;
      align_err_d = tgt_misaligned;
    end else begin
      ia_d = ia_inc;
    end
  end

  // PC, RAS pointer/count and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ia_q        <= RESET_VEC;
      top_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      ia_q        <= ia_d;
      top_q       <= top_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      align_err_q <= align_err_d;
    end
  end

  // RAS storage; contents are don't-care while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (ras_we && !reset) begin
      ras_q[ras_waddr] <= ras_wdata;
    end
  end

  assign ia        = ia_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = cnt_full;
  assign ras_ovf   = ovf_q;
  assign align_err = align_err_q;

endmodule
